// File: rtl/quadrature_step_generator_if.sv
// Request/status bundle for the quadrature step generator.
// master = requester (drives step pulses), slave = generator.
interface quadrature_step_generator_if #(
  parameter int MAX_PENDING = 15
) ();
  localparam int P = $clog2(MAX_PENDING + 1) + 1;

  logic                enable;
  logic                stepCw;
  logic                stepCcw;
  logic                A;
  logic                B;
  logic                busy;
  logic                stepDone;
  logic                overflow;
  logic signed [P-1:0] pendingSteps;

  modport master (
    output enable, stepCw, stepCcw,
    input  A, B, busy, stepDone, overflow, pendingSteps
  );

  modport slave (
    input  enable, stepCw, stepCcw,
    output A, B, busy, stepDone, overflow, pendingSteps
  );
endinterface

// File: rtl/quadrature_step_generator.sv
// Turns cw/ccw step requests into paced Gray-code A/B edges.
// Requests accumulate in a saturating signed counter; an IDLE/WAIT/EDGE FSM plays them out.
module quadrature_step_generator #(
  parameter int STEP_PERIOD    = 50_000,
  parameter int EDGES_PER_STEP = 4,
  parameter int MAX_PENDING    = 15
) (
  input logic                         clk,
  input logic                         reset,
  quadrature_step_generator_if.slave  bus
);
  localparam int P  = $clog2(MAX_PENDING + 1) + 1;
  localparam int W  = P + 2;
  localparam int DW = $clog2(STEP_PERIOD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] EDGE = 2'd2;

  localparam logic signed [W-1:0] ONE     = W'(1);
  localparam logic signed [W-1:0] MAX_POS = W'(MAX_PENDING);
  localparam logic signed [W-1:0] MAX_NEG = -MAX_POS;

  logic [1:0]          state_reg, state_next;
  logic [DW-1:0]       divider_reg, divider_next;
  logic [2:0]          edge_count_reg, edge_count_next;
  logic                dir_reg, dir_next;  // 1 = clockwise
  logic [1:0]          phase_reg, phase_next;
  logic                a_reg, b_reg;
  logic                step_done_reg, step_done_next;
  logic                overflow_reg, overflow_next;
  logic signed [P-1:0] pending_reg, pending_next;
  logic                done_cw, done_ccw;

  logic signed [W-1:0] pending_ext, req, done_amt, base, with_req;

  always_comb begin
    state_next      = state_reg;
    divider_next    = divider_reg;
    edge_count_next = edge_count_reg;
    dir_next        = dir_reg;
    phase_next      = phase_reg;
    step_done_next  = 1'b0;
    done_cw         = 1'b0;
    done_ccw        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.enable && (pending_reg != '0)) begin
          state_next      = WAIT;
          dir_next        = ~pending_reg[P-1];
          edge_count_next = '0;
          divider_next    = '0;
        end
      end
      WAIT: begin
        if (bus.enable) begin
          if (divider_reg == DW'(STEP_PERIOD - 1)) begin
            state_next = EDGE;
          end else begin
            divider_next = divider_reg + 1'b1;
          end
        end
      end
      EDGE: begin
        phase_next      = dir_reg ? (phase_reg + 2'd1) : (phase_reg - 2'd1);
        edge_count_next = edge_count_reg + 3'd1;
        if (edge_count_reg == 3'(EDGES_PER_STEP - 1)) begin
          step_done_next = 1'b1;
          done_cw        = dir_reg;
          done_ccw       = ~dir_reg;
          state_next     = IDLE;
        end else begin
          divider_next = '0;
          state_next   = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion is always applied; only the request part is dropped at saturation.
  always_comb begin
    pending_ext = {{2{pending_reg[P-1]}}, pending_reg};
    req         = '0;
    done_amt    = '0;
    if (bus.stepCw && !bus.stepCcw) req = ONE;
    if (bus.stepCcw && !bus.stepCw) req = -ONE;
    if (done_cw)  done_amt = ONE;
    if (done_ccw) done_amt = -ONE;
    base          = pending_ext - done_amt;
    with_req      = base + req;
    overflow_next = 1'b0;
    pending_next  = with_req[P-1:0];
    if ((req != '0) && ((with_req > MAX_POS) || (with_req < MAX_NEG))) begin
      overflow_next = 1'b1;
      pending_next  = base[P-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      divider_reg    <= '0;
      edge_count_reg <= '0;
      dir_reg        <= 1'b0;
      phase_reg      <= 2'd0;
      a_reg          <= 1'b0;
      b_reg          <= 1'b0;
      step_done_reg  <= 1'b0;
      overflow_reg   <= 1'b0;
      pending_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      divider_reg    <= divider_next;
      edge_count_reg <= edge_count_next;
      dir_reg        <= dir_next;
      phase_reg      <= phase_next;
      a_reg          <= phase_next[1] ^ phase_next[0];
      b_reg          <= phase_next[1];
      step_done_reg  <= step_done_next;
      overflow_reg   <= overflow_next;
      pending_reg    <= pending_next;
    end
  end

  assign bus.A            = a_reg;
  assign bus.B            = b_reg;
  assign bus.busy         = (state_reg != IDLE);
  assign bus.stepDone     = step_done_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.pendingSteps = pending_reg;
endmodule

// File: tb/tb_quadrature_step_generator.sv
// Directed bench for quadrature_step_generator with STEP_PERIOD=4, EDGES_PER_STEP=4, MAX_PENDING=3.
module tb_quadrature_step_generator;
  localparam int SP   = 4;
  localparam int EPS  = 4;
  localparam int MAXP = 3;

  localparam logic [1:0] CW_SEQ  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] CCW_SEQ [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  quadrature_step_generator_if #(.MAX_PENDING(MAXP)) bus ();

  quadrature_step_generator #(
    .STEP_PERIOD(SP), .EDGES_PER_STEP(EPS), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until A/B changes (bounded); a timeout leaves ab unchanged so checks fail.
  task automatic wait_edge(output int cycles, output logic [1:0] ab, output logic done);
    logic [1:0] start;
    start  = {bus.A, bus.B};
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (({bus.A, bus.B} === start) && (cycles < 40));
    ab   = {bus.A, bus.B};
    done = bus.stepDone;
  endtask

  task automatic run_out(output int steps, output int ovfs, output logic [1:0] first_ab,
                         output int cycles);
    logic [1:0] start;
    logic       seen;
    start = {bus.A, bus.B};
    first_ab = start;
    seen = 1'b0;
    steps = 0;
    ovfs = 0;
    cycles = 0;
    do begin
      tick();
      cycles++;
      if (bus.stepDone === 1'b1) steps++;
      if (bus.overflow === 1'b1) ovfs++;
      if (!seen && ({bus.A, bus.B} !== start)) begin
        first_ab = {bus.A, bus.B};
        seen = 1'b1;
      end
    end while (!((bus.busy === 1'b0) && (bus.pendingSteps === '0)) && (cycles < 400));
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.A, bus.B} !== 2'b00) begin bad++; $display("FAIL reset_ab got=%b want=00", {bus.A, bus.B}); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++;
    if (bus.pendingSteps !== '0) begin bad++; $display("FAIL reset_pending got=%0d want=0", bus.pendingSteps); end
    total++;
    if ({bus.stepDone, bus.overflow} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b want=00", {bus.stepDone, bus.overflow}); end
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single_step(input bit cw);
    int c;
    logic [1:0] ab, exp_ab;
    logic d;
    int exp_p;
    if (cw) bus.stepCw = 1'b1; else bus.stepCcw = 1'b1;
    tick();
    bus.stepCw = 1'b0;
    bus.stepCcw = 1'b0;
    exp_p = cw ? 1 : -1;
    total++;
    if (int'(bus.pendingSteps) !== exp_p) begin bad++; $display("FAIL step_pending got=%0d want=%0d", bus.pendingSteps, exp_p); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL step_busy_idle got=%b want=0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      wait_edge(c, ab, d);
      exp_ab = cw ? CW_SEQ[i] : CCW_SEQ[i];
      total++;
      if (ab !== exp_ab) begin bad++; $display("FAIL step_ab%0d got=%b want=%b", i, ab, exp_ab); end
      total++;
      if (c !== ((i == 0) ? SP + 2 : SP + 1)) begin bad++; $display("FAIL step_gap%0d got=%0d want=%0d", i, c, (i == 0) ? SP + 2 : SP + 1); end
      total++;
      if (d !== (i == 3)) begin bad++; $display("FAIL step_done%0d got=%b want=%b", i, d, (i == 3)); end
    end
    total++;
    if (bus.pendingSteps !== '0) begin bad++; $display("FAIL step_final_pending got=%0d want=0", bus.pendingSteps); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL step_final_busy got=%b want=0", bus.busy); end
    tick();
    total++;
    if (bus.stepDone !== 1'b0) begin bad++; $display("FAIL step_done_width got=%b want=0", bus.stepDone); end
    $display("test_single_step cw=%0d done", cw);
  endtask

  task automatic test_saturation();
    int exp_p [5] = '{1, 2, 3, 3, 3};
    logic exp_o [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int steps, ovfs, cyc;
    logic [1:0] fab;
    bus.stepCw = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (int'(bus.pendingSteps) !== exp_p[i]) begin bad++; $display("FAIL sat_pending%0d got=%0d want=%0d", i, bus.pendingSteps, exp_p[i]); end
      total++;
      if (bus.overflow !== exp_o[i]) begin bad++; $display("FAIL sat_overflow%0d got=%b want=%b", i, bus.overflow, exp_o[i]); end
    end
    bus.stepCw = 1'b0;
    run_out(steps, ovfs, fab, cyc);
    total++;
    if (steps !== 3) begin bad++; $display("FAIL sat_steps got=%0d want=3", steps); end
    total++;
    if (cyc >= 400) begin bad++; $display("FAIL sat_timeout got=%0d want<400", cyc); end
    total++;
    if ({bus.A, bus.B} !== 2'b00) begin bad++; $display("FAIL sat_final_ab got=%b want=00", {bus.A, bus.B}); end
    $display("test_saturation steps=%0d", steps);
  endtask

  task automatic test_cancel();
    logic seen_busy;
    bus.stepCw = 1'b1;
    bus.stepCcw = 1'b1;
    tick();
    bus.stepCw = 1'b0;
    bus.stepCcw = 1'b0;
    total++;
    if (bus.pendingSteps !== '0) begin bad++; $display("FAIL cancel_pending got=%0d want=0", bus.pendingSteps); end
    total++;
    if (bus.overflow !== 1'b0) begin bad++; $display("FAIL cancel_overflow got=%b want=0", bus.overflow); end
    seen_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.busy !== 1'b0) seen_busy = 1'b1;
    end
    total++;
    if (seen_busy !== 1'b0) begin bad++; $display("FAIL cancel_busy got=%b want=0", seen_busy); end
    $display("test_cancel done");
  endtask

  task automatic test_reversal();
    int c, steps, ovfs, cyc;
    logic [1:0] ab, fab;
    logic d;
    bus.stepCw = 1'b1;
    tick();
    tick();
    bus.stepCw = 1'b0;
    total++;
    if (int'(bus.pendingSteps) !== 2) begin bad++; $display("FAIL rev_pending2 got=%0d want=2", bus.pendingSteps); end
    wait_edge(c, ab, d);
    total++;
    if (ab !== 2'b10) begin bad++; $display("FAIL rev_first_ab got=%b want=10", ab); end
    bus.stepCcw = 1'b1;
    tick();
    tick();
    tick();
    bus.stepCcw = 1'b0;
    total++;
    if (int'(bus.pendingSteps) !== -1) begin bad++; $display("FAIL rev_pending_neg got=%0d want=-1", bus.pendingSteps); end
    for (int i = 1; i < 4; i++) begin
      wait_edge(c, ab, d);
      total++;
      if (ab !== CW_SEQ[i]) begin bad++; $display("FAIL rev_cw_ab%0d got=%b want=%b", i, ab, CW_SEQ[i]); end
    end
    total++;
    if (d !== 1'b1) begin bad++; $display("FAIL rev_cw_done got=%b want=1", d); end
    // Net request is -1 and one CW step went out, so two CCW steps remain.
    total++;
    if (int'(bus.pendingSteps) !== -2) begin bad++; $display("FAIL rev_pending_after got=%0d want=-2", bus.pendingSteps); end
    run_out(steps, ovfs, fab, cyc);
    total++;
    if (fab !== 2'b01) begin bad++; $display("FAIL rev_ccw_dir got=%b want=01", fab); end
    total++;
    if (steps !== 2) begin bad++; $display("FAIL rev_ccw_steps got=%0d want=2", steps); end
    total++;
    if ({bus.A, bus.B} !== 2'b00) begin bad++; $display("FAIL rev_final_ab got=%b want=00", {bus.A, bus.B}); end
    $display("test_reversal ccw_steps=%0d", steps);
  endtask

  task automatic test_reset_mid();
    int c;
    logic [1:0] ab;
    logic d;
    bus.stepCw = 1'b1;
    tick();
    bus.stepCw = 1'b0;
    wait_edge(c, ab, d);
    wait_edge(c, ab, d);
    total++;
    if (ab !== 2'b11) begin bad++; $display("FAIL rmid_pre_ab got=%b want=11", ab); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if ({bus.A, bus.B} !== 2'b00) begin bad++; $display("FAIL rmid_ab got=%b want=00", {bus.A, bus.B}); end
    total++;
    if (bus.pendingSteps !== '0) begin bad++; $display("FAIL rmid_pending got=%0d want=0", bus.pendingSteps); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_enable_freeze();
    int c;
    logic [1:0] ab;
    logic d, frozen;
    bus.stepCw = 1'b1;
    tick();
    bus.stepCw = 1'b0;
    wait_edge(c, ab, d);
    tick();
    tick();
    bus.enable = 1'b0;
    frozen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (({bus.A, bus.B} !== 2'b10) || (bus.busy !== 1'b1)) frozen = 1'b0;
    end
    total++;
    if (frozen !== 1'b1) begin bad++; $display("FAIL freeze_hold got=%b want=1", frozen); end
    bus.enable = 1'b1;
    wait_edge(c, ab, d);
    total++;
    if (ab !== 2'b11) begin bad++; $display("FAIL freeze_resume_ab got=%b want=11", ab); end
    total++;
    if (c !== 3) begin bad++; $display("FAIL freeze_resume_gap got=%0d want=3", c); end
    wait_edge(c, ab, d);
    wait_edge(c, ab, d);
    total++;
    if ((ab !== 2'b00) || (d !== 1'b1)) begin bad++; $display("FAIL freeze_finish got=%b/%b want=00/1", ab, d); end
    total++;
    if (bus.pendingSteps !== '0) begin bad++; $display("FAIL freeze_pending got=%0d want=0", bus.pendingSteps); end
    $display("test_enable_freeze done");
  endtask

  initial begin
    bus.enable  = 1'b1;
    bus.stepCw  = 1'b0;
    bus.stepCcw = 1'b0;
    test_reset();
    test_single_step(1'b1);
    test_single_step(1'b0);
    test_saturation();
    test_cancel();
    test_reversal();
    test_reset_mid();
    test_enable_freeze();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
